// File: rtl/timer_irq_source_if.sv
// Data-memory bus bundle between the CPU load/store path and the timer.
// Latency: none, wires only.
// Backpressure: none; the bus completes every access in the cycle it is presented.
//
// Ports (signals):
//   Addr      - byte address from the ALU result
//   WriteData - store data (rt)
//   MemWr     - store strobe, same cycle as Addr
//   MemRd     - load strobe
//   ReadData  - load data returned by the slave, combinational
//   Sel       - slave decodes Addr as one of its registers
interface timer_irq_source_if;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemWr;
  logic        MemRd;
  logic [31:0] ReadData;
  logic        Sel;

  modport master (
    output Addr, WriteData, MemWr, MemRd,
    input  ReadData, Sel
  );

  modport slave (
    input  Addr, WriteData, MemWr, MemRd,
    output ReadData, Sel
  );
endinterface

// File: rtl/timer_irq_source.sv
// Memory-mapped 32-bit reload timer raising a level interrupt on TL overflow.
// Latency: reads are combinational; writes and counting take effect at the next clk edge.
// Backpressure: none; every bus access is accepted in the cycle it is presented.
//
// Ports:
//   clk         - system clock, all state on the rising edge
//   reset       - asynchronous active-low reset
//   bus         - data-memory bus slave (Addr, WriteData, MemWr, MemRd, ReadData, Sel)
//   kernel_mode - PC[31] of the current instruction; masks the interrupt while set
//   Interrupt   - level interrupt request to the control unit
//
// Register map: TH at BASE_ADDR, TL at +4, TCON at +8 (EN=bit0, IE=bit1, IS=bit2).
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                clk,
  input  logic                reset,
  timer_irq_source_if.slave   bus,
  input  logic                kernel_mode,
  output logic                Interrupt
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST  = PCW'(PRESCALE - 1);
  localparam logic [29:0]    WA_TH    = BASE_ADDR[31:2];
  localparam logic [29:0]    WA_TL    = WA_TH + 30'd1;
  localparam logic [29:0]    WA_TCON  = WA_TH + 30'd2;

  logic [31:0]    r_th;
  logic [31:0]    r_tl;
  logic           r_en;
  logic           r_ie;
  logic           r_is;
  logic [PCW-1:0] r_pc;

  logic           w_hit_th;
  logic           w_hit_tl;
  logic           w_hit_tcon;
  logic           w_sel;
  logic           w_wr_th;
  logic           w_wr_tl;
  logic           w_wr_tcon;
  logic           w_tick;
  logic           w_ovf;
  logic           w_ie_next;
  logic           w_is_next;
  logic [31:0]    w_rdata;
  logic           w_unused_addr_lo;

  // Byte offset within the word is don't-care: any access to a register's word hits it.
  assign w_unused_addr_lo = &{1'b0, bus.Addr[1:0]};

  assign w_hit_th   = (bus.Addr[31:2] == WA_TH);
  assign w_hit_tl   = (bus.Addr[31:2] == WA_TL);
  assign w_hit_tcon = (bus.Addr[31:2] == WA_TCON);
  assign w_sel      = w_hit_th | w_hit_tl | w_hit_tcon;

  assign w_wr_th    = bus.MemWr & w_hit_th;
  assign w_wr_tl    = bus.MemWr & w_hit_tl;
  assign w_wr_tcon  = bus.MemWr & w_hit_tcon;

  // Tick uses the EN value in force before this edge; a TCON write changes EN afterwards.
  assign w_tick = r_en & (r_pc == PC_LAST);
  assign w_ovf  = w_tick & (r_tl == 32'hFFFF_FFFF);

  // OR-ing the overflow in after the software value means a clear that collides with
  // an overflow still leaves IS set, so the event is never dropped.
  assign w_ie_next = w_wr_tcon ? bus.WriteData[1] : r_ie;
  assign w_is_next = (w_wr_tcon ? bus.WriteData[2] : r_is) | (w_ovf & w_ie_next);

  // Prescaler: holds (not cleared) while EN=0 so the phase resumes where it stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (r_en) begin
      r_pc <= w_tick ? '0 : r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th <= '0;
      r_tl <= '0;
      r_en <= 1'b0;
      r_ie <= 1'b0;
      r_is <= 1'b0;
    end else begin
      if (w_wr_th) begin
        r_th <= bus.WriteData;
      end
      // A software TL write beats both increment and reload. The reload samples the
      // old TH, so a TH write in the overflow cycle only affects the next wrap.
      if (w_wr_tl) begin
        r_tl <= bus.WriteData;
      end else if (w_tick) begin
        r_tl <= w_ovf ? r_th : r_tl + 32'd1;
      end
      if (w_wr_tcon) begin
        r_en <= bus.WriteData[0];
        r_ie <= bus.WriteData[1];
      end
      r_is <= w_is_next;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (bus.MemRd) begin
      if (w_hit_th) begin
        w_rdata = r_th;
      end else if (w_hit_tl) begin
        w_rdata = r_tl;
      end else if (w_hit_tcon) begin
        w_rdata = {29'd0, r_is, r_ie, r_en};
      end
    end
  end

  assign bus.ReadData = w_rdata;
  assign bus.Sel      = w_sel;

  // The handler runs in kernel mode, so the request drops on entry and comes back on
  // return to user mode if IS was left set.
  assign Interrupt = r_is & r_ie & ~kernel_mode;

endmodule

// File: tb/tb_timer_irq_source.sv
// Scoreboard bench: stimulus pushes expected read/Sel/Interrupt values; a negedge monitor
// pops and compares. Two instances share the bus drive: PRESCALE=1 (dut 0) and 4 (dut 1).
module tb_timer_irq_source;

  localparam logic [31:0] A_TH = 32'h4000_0000;
  localparam logic [31:0] A_TL = 32'h4000_0004;
  localparam logic [31:0] A_TC = 32'h4000_0008;

  typedef struct {
    int          dut;
    int          id;
    logic [31:0] rd;
    logic        sel;
    logic        irq;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memwr;
  logic        memrd;
  logic        kmode;
  logic        irq_p1;
  logic        irq_p4;
  logic        probe;

  int   n_pass;
  int   n_total;
  int   chk_id;
  exp_t sb_q[$];
  exp_t m_e;
  logic [31:0] m_rd;
  logic        m_sel;
  logic        m_irq;

  timer_irq_source_if bus_p1();
  timer_irq_source_if bus_p4();

  assign bus_p1.Addr      = addr;
  assign bus_p1.WriteData = wdata;
  assign bus_p1.MemWr     = memwr;
  assign bus_p1.MemRd     = memrd;
  assign bus_p4.Addr      = addr;
  assign bus_p4.WriteData = wdata;
  assign bus_p4.MemWr     = memwr;
  assign bus_p4.MemRd     = memrd;

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) u_p1 (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus_p1),
    .kernel_mode (kmode),
    .Interrupt   (irq_p1)
  );

  timer_irq_source #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) u_p4 (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus_p4),
    .kernel_mode (kmode),
    .Interrupt   (irq_p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL chk%0d.%s actual=0x%08h expected=0x%08h", id, nm, act, exp);
  endtask

  // Monitor: compares whenever the stimulus presents a probed cycle.
  always @(negedge clk) begin
    if (probe) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard: probe with empty expectation queue");
      end else begin
        m_e   = sb_q.pop_front();
        m_rd  = (m_e.dut == 0) ? bus_p1.ReadData : bus_p4.ReadData;
        m_sel = (m_e.dut == 0) ? bus_p1.Sel      : bus_p4.Sel;
        m_irq = (m_e.dut == 0) ? irq_p1          : irq_p4;
        cmp("ReadData",  m_e.id, m_rd,          m_e.rd);
        cmp("Sel",       m_e.id, {31'd0, m_sel}, {31'd0, m_e.sel});
        cmp("Interrupt", m_e.id, {31'd0, m_irq}, {31'd0, m_e.irq});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    addr  = a;
    wdata = v;
    memwr = 1'b1;
    @(posedge clk);
    #1;
    memwr = 1'b0;
  endtask

  // Present a read (or non-read) and queue the expected outputs for the next negedge.
  task automatic chk(input int d, input logic [31:0] a, input logic rd_on,
                     input logic [31:0] e_rd, input logic e_sel, input logic e_irq);
    exp_t e;
    addr  = a;
    memrd = rd_on;
    e.dut = d;
    e.id  = chk_id;
    e.rd  = e_rd;
    e.sel = e_sel;
    e.irq = e_irq;
    chk_id++;
    sb_q.push_back(e);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
    memrd = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    chk_id  = 0;
    probe   = 1'b0;
    rst_n   = 1'b0;
    addr    = 32'd0;
    wdata   = 32'd0;
    memwr   = 1'b0;
    memrd   = 1'b0;
    kmode   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state and decode
    chk(0, A_TH, 1'b1, 32'd0, 1'b1, 1'b0);
    chk(0, A_TL, 1'b1, 32'd0, 1'b1, 1'b0);
    chk(0, A_TC, 1'b1, 32'd0, 1'b1, 1'b0);
    chk(1, A_TL, 1'b1, 32'd0, 1'b1, 1'b0);
    chk(0, 32'h4000_0010, 1'b1, 32'd0, 1'b0, 1'b0);

    // Overflow with PRESCALE=1
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'd3);
    chk(0, A_TL, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    chk(0, A_TL, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk(0, A_TC, 1'b1, 32'd7,         1'b1, 1'b1);
    chk(0, A_TL, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    chk(0, A_TL, 1'b0, 32'd0,         1'b1, 1'b1);

    // Kernel-mode masking, clear, and reassert when IS left set
    kmode = 1'b1;
    chk(0, A_TC, 1'b1, 32'd7, 1'b1, 1'b0);
    wr(A_TH, 32'd0);
    wr(A_TL, 32'd0);
    wr(A_TC, 32'd3);
    kmode = 1'b0;
    chk(0, A_TC, 1'b1, 32'd3, 1'b1, 1'b0);
    chk(0, A_TL, 1'b1, 32'd2, 1'b1, 1'b0);
    kmode = 1'b1;
    wr(A_TL, 32'hFFFF_FFFF);
    step();
    chk(0, A_TC, 1'b1, 32'd7, 1'b1, 1'b0);
    kmode = 1'b0;
    chk(0, A_TL, 1'b1, 32'd1, 1'b1, 1'b1);

    // TCON write colliding with overflow
    wr(A_TC, 32'd3);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'd3);
    chk(0, A_TC, 1'b1, 32'd7, 1'b1, 1'b1);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'd1);
    chk(0, A_TC, 1'b1, 32'd1, 1'b1, 1'b0);
    chk(0, A_TL, 1'b1, 32'd1, 1'b1, 1'b0);

    // Software-set IS
    wr(A_TC, 32'd5);
    chk(0, A_TC, 1'b1, 32'd5, 1'b1, 1'b0);
    wr(A_TC, 32'd6);
    chk(0, A_TC, 1'b1, 32'd6, 1'b1, 1'b1);
    wr(A_TC, 32'd0);

    // TH write in the overflow cycle reloads the old TH
    wr(A_TH, 32'h0000_0100);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'd1);
    step();
    wr(A_TH, 32'h0000_0200);
    chk(0, A_TL, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    wr(A_TC, 32'd0);
    chk(0, A_TH, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    chk(0, A_TL, 1'b1, 32'h0000_0101, 1'b1, 1'b0);

    // PRESCALE=4: count, pause mid-phase, resume
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wr(A_TL, 32'd0);
    wr(A_TC, 32'd1);
    repeat (12) step();
    chk(1, A_TL, 1'b1, 32'd3, 1'b1, 1'b0);
    step();
    wr(A_TC, 32'd0);
    repeat (5) step();
    chk(1, A_TL, 1'b1, 32'd3, 1'b1, 1'b0);
    wr(A_TC, 32'd1);
    step();
    chk(1, A_TL, 1'b1, 32'd3, 1'b1, 1'b0);
    step();
    chk(1, A_TL, 1'b1, 32'd4, 1'b1, 1'b0);

    // Asynchronous reset mid-count
    kmode = 1'b0;
    wr(A_TC, 32'd7);
    wr(A_TL, 32'h0000_1234);
    chk(0, A_TL, 1'b1, 32'h0000_1234, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    chk(0, A_TL, 1'b1, 32'd0, 1'b1, 1'b0);
    chk(0, A_TC, 1'b1, 32'd0, 1'b1, 1'b0);
    chk(1, A_TL, 1'b1, 32'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    chk(0, A_TL, 1'b1, 32'd0, 1'b1, 1'b0);

    // Byte offset ignored; unmapped writes ignored
    wr(A_TL + 32'd2, 32'h0000_0055);
    chk(0, A_TL + 32'd1, 1'b1, 32'h0000_0055, 1'b1, 1'b0);
    wr(32'h4000_000C, 32'h0000_DEAD);
    chk(0, A_TL, 1'b1, 32'h0000_0055, 1'b1, 1'b0);
    chk(0, A_TH + 32'd3, 1'b1, 32'd0, 1'b1, 1'b0);
    chk(0, 32'h4000_000C, 1'b1, 32'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
